// File: rtl/h264intra8x8cc_fb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | h264intra8x8cc_fb_pkg : shared types and pixel helpers for the responder |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package h264intra8x8cc_fb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WAIT    = 2'd2,
    EMIT    = 2'd3
  } fb_state_t;

  localparam int PIX_W = 8;
  localparam int RES_W = 9;

  // Base is 0..255 and residual -256..255, so a 10-bit signed sum never overflows.
  function automatic logic signed [RES_W:0] wide_sum(input logic [PIX_W-1:0] base8,
                                                     input logic [RES_W-1:0] res9);
    return $signed({2'b00, base8}) + $signed({res9[RES_W-1], res9});
  endfunction

  function automatic logic [PIX_W-1:0] clip_add(input logic [PIX_W-1:0] base8,
                                                input logic [RES_W-1:0] res9);
    logic signed [RES_W:0] s;
    s = wide_sum(base8, res9);
    if (s[RES_W])
      return '0;
    else if (s[PIX_W])
      return '1;
    else
      return s[PIX_W-1:0];
  endfunction

  function automatic logic clip_sat(input logic [PIX_W-1:0] base8,
                                    input logic [RES_W-1:0] res9);
    logic signed [RES_W:0] s;
    s = wide_sum(base8, res9);
    return s[RES_W] | s[PIX_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/h264intra8x8cc_fbrecon4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | h264intra8x8cc_fbrecon4 : 4-lane clip(base + residual) reconstruction    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module h264intra8x8cc_fbrecon4
  import h264intra8x8cc_fb_pkg::*;
(
  input  logic [31:0] base,
  input  logic [35:0] res,
  output logic [31:0] pix
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign pix[PIX_W*i +: PIX_W] = clip_add(base[PIX_W*i +: PIX_W], res[RES_W*i +: RES_W]);
  end

endmodule
`default_nettype wire

// File: rtl/h264intra8x8cc_fbresponder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | h264intra8x8cc_fbresponder : collects a 4x4 chroma residual block and    |
// | returns clipped reconstructed rows; H264_FB_CLIPCOUNT_EN adds CLIPCOUNT. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module h264intra8x8cc_fbresponder
  import h264intra8x8cc_fb_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ROWS    = 4
) (
  input  logic        CLK2,
  input  logic        NEWLINE,
  input  logic        STROBEI,
  input  logic [35:0] DATAI,
  input  logic [31:0] BASEI,
  input  logic        CRCBI,
  output logic        READYO,
  output logic        FBSTROBE,
  output logic [31:0] FEEDB,
  output logic        FBCRCB,
  output logic        FBPENDING,
  output logic        OVERRUN
`ifdef H264_FB_CLIPCOUNT_EN
  ,
  output logic [15:0] CLIPCOUNT
`endif
);

  localparam int                 c_row_w    = $clog2(ROWS);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(ROWS - 1);
  localparam logic [c_row_w-1:0] c_row_one  = c_row_w'(1);
  localparam logic [3:0]         c_lat      = 4'(LATENCY);
  localparam logic               c_lat_zero = (LATENCY == 0);

  fb_state_t          r_state;
  logic [c_row_w-1:0] r_row;
  logic [3:0]         r_lat;
  logic [31:0]        r_base [ROWS];
  logic [35:0]        r_res  [ROWS];

  logic [c_row_w-1:0] w_sel;
  logic [31:0]        w_base_row;
  logic [35:0]        w_res_row;
  logic [31:0]        w_pix;
  logic               w_capture;
  logic               w_last_cap;
  logic               w_emit;

  assign w_capture  = STROBEI && (r_state == IDLE || r_state == COLLECT);
  assign w_last_cap = STROBEI && (r_state == COLLECT) && (r_row == c_row_last);

  // Row 0 leaves on entry to EMIT; inside EMIT r_row points at the next row to send.
  assign w_sel      = (r_state == EMIT) ? r_row : '0;
  assign w_base_row = r_base[w_sel];
  assign w_res_row  = r_res[w_sel];

  assign w_emit = (w_last_cap && c_lat_zero)
               || (r_state == WAIT && r_lat == 4'd1)
               || (r_state == EMIT && r_row != '0);

  always_ff @(posedge CLK2) begin
    if (w_capture) begin
      r_base[r_row] <= BASEI;
      r_res[r_row]  <= DATAI;
    end
  end

  h264intra8x8cc_fbrecon4 u_recon (
    .base (w_base_row),
    .res  (w_res_row),
    .pix  (w_pix)
  );

  always_ff @(posedge CLK2 or posedge NEWLINE) begin
    if (NEWLINE) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_lat     <= '0;
      READYO    <= 1'b1;
      FBSTROBE  <= 1'b0;
      FEEDB     <= '0;
      FBCRCB    <= 1'b0;
      FBPENDING <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (STROBEI && (r_state == WAIT || r_state == EMIT))
        OVERRUN <= 1'b1;
      FBSTROBE <= w_emit;
      if (w_emit)
        FEEDB <= w_pix;
      case (r_state)
        IDLE: begin
          if (STROBEI) begin
            FBCRCB    <= CRCBI;
            FBPENDING <= 1'b1;
            READYO    <= 1'b0;
            r_row     <= c_row_one;
            r_state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_last_cap) begin
            if (c_lat_zero) begin
              r_row   <= c_row_one;
              r_state <= EMIT;
            end else begin
              r_lat   <= c_lat;
              r_row   <= '0;
              r_state <= WAIT;
            end
          end else if (STROBEI) begin
            r_row <= r_row + c_row_one;
          end
        end
        WAIT: begin
          if (r_lat == 4'd1) begin
            r_lat   <= '0;
            r_row   <= c_row_one;
            r_state <= EMIT;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        EMIT: begin
          // r_row wraps to 0 after row 3 goes out; one more cycle closes the block.
          if (r_row == '0) begin
            FBPENDING <= 1'b0;
            READYO    <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_row <= r_row + c_row_one;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef H264_FB_CLIPCOUNT_EN
  logic [2:0]  w_nsat;
  logic [16:0] w_clip_sum;

  always_comb begin
    w_nsat = '0;
    for (int i = 0; i < 4; i++)
      w_nsat = w_nsat + {2'b00, clip_sat(w_base_row[PIX_W*i +: PIX_W], w_res_row[RES_W*i +: RES_W])};
  end

  assign w_clip_sum = {1'b0, CLIPCOUNT} + {14'd0, w_nsat};

  always_ff @(posedge CLK2 or posedge NEWLINE) begin
    if (NEWLINE)
      CLIPCOUNT <= '0;
    else if (w_emit)
      CLIPCOUNT <= w_clip_sum[16] ? 16'hFFFF : w_clip_sum[15:0];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_h264intra8x8cc_fbresponder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_h264intra8x8cc_fbresponder : directed + random block checks, LAT 2/0  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_h264intra8x8cc_fbresponder;

  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_stb = 1'b0, a_crcb = 1'b0;
  logic [35:0] a_dat = '0;
  logic [31:0] a_base = '0;
  logic        a_ready, a_fbs, a_fbcrcb, a_pend, a_ovr;
  logic [31:0] a_feedb;
  logic        b_stb = 1'b0, b_crcb = 1'b0;
  logic [35:0] b_dat = '0;
  logic [31:0] b_base = '0;
  logic        b_ready, b_fbs, b_fbcrcb, b_pend, b_ovr;
  logic [31:0] b_feedb;
`ifdef H264_FB_CLIPCOUNT_EN
  logic [15:0] a_clip, b_clip;
`endif

  h264intra8x8cc_fbresponder #(.LATENCY(LAT_A), .ROWS(4)) u_dut_a (
    .CLK2(clk), .NEWLINE(rst), .STROBEI(a_stb), .DATAI(a_dat), .BASEI(a_base),
    .CRCBI(a_crcb), .READYO(a_ready), .FBSTROBE(a_fbs), .FEEDB(a_feedb),
    .FBCRCB(a_fbcrcb), .FBPENDING(a_pend), .OVERRUN(a_ovr)
`ifdef H264_FB_CLIPCOUNT_EN
    , .CLIPCOUNT(a_clip)
`endif
  );

  h264intra8x8cc_fbresponder #(.LATENCY(0), .ROWS(4)) u_dut_b (
    .CLK2(clk), .NEWLINE(rst), .STROBEI(b_stb), .DATAI(b_dat), .BASEI(b_base),
    .CRCBI(b_crcb), .READYO(b_ready), .FBSTROBE(b_fbs), .FEEDB(b_feedb),
    .FBCRCB(b_fbcrcb), .FBPENDING(b_pend), .OVERRUN(b_ovr)
`ifdef H264_FB_CLIPCOUNT_EN
    , .CLIPCOUNT(b_clip)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] exp_a[$], obs_a[$];
  int          obs_a_cyc[$];
  logic [33:0] exp_b[$], obs_b[$];
  int          obs_b_cyc[$];
  int          runs_b[$];
  int          run_b = 0;
  int          pend_b = 0;
  int          clip_a = 0, clip_b = 0;
  logic [31:0] blk_b [4];
  logic [35:0] blk_r [4];

  always @(negedge clk) begin
    if (a_fbs) begin
      obs_a.push_back({a_fbcrcb, a_feedb});
      obs_a_cyc.push_back(cyc);
    end
    if (b_fbs) begin
      obs_b.push_back({b_pend, b_fbcrcb, b_feedb});
      obs_b_cyc.push_back(cyc);
    end
    if (b_pend) pend_b++;
    if (b_ready) run_b++;
    else if (run_b > 0) begin
      runs_b.push_back(run_b);
      run_b = 0;
    end
  end

  // Reference reconstruction: plain integer add then clamp to 0..255.
  function automatic logic [31:0] ref_row(input logic [31:0] b, input logic [35:0] r);
    logic [31:0] o;
    logic signed [8:0] r9;
    int s;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      r9 = r[9*i +: 9];
      s  = int'(b[8*i +: 8]) + int'(r9);
      if (s < 0) s = 0;
      else if (s > 255) s = 255;
      o[8*i +: 8] = 8'(s);
    end
    return o;
  endfunction

  function automatic int ref_nsat(input logic [31:0] b, input logic [35:0] r);
    logic signed [8:0] r9;
    int s, n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      r9 = r[9*i +: 9];
      s  = int'(b[8*i +: 8]) + int'(r9);
      if (s < 0 || s > 255) n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_blk();
    for (int i = 0; i < 4; i++) begin
      blk_b[i] = $urandom;
      blk_r[i] = 36'({$urandom, $urandom});
    end
  endtask

  task automatic a_row(input logic [31:0] b, input logic [35:0] r, input logic crc);
    a_stb = 1'b1; a_base = b; a_dat = r; a_crcb = crc;
    @(posedge clk); #1;
    a_stb = 1'b0;
  endtask

  task automatic a_wait_ready();
    int g;
    g = 0;
    while (!a_ready && g < 100) begin @(posedge clk); #1; g++; end
    if (!a_ready) chk("ready timeout", 64'(a_ready), 64'd1);
  endtask

  task automatic a_send(input int gap, input logic crc0, output int r3c);
    a_wait_ready();
    r3c = 0;
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back({crc0, ref_row(blk_b[i], blk_r[i])});
      clip_a += ref_nsat(blk_b[i], blk_r[i]);
      if (i == 3) r3c = cyc;
      a_row(blk_b[i], blk_r[i], crc0 ^ i[0]);
      if (i < 3) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic a_check(input string tag, input int r3c);
    int g, c0, c3;
    logic [32:0] o, e;
    g = 0;
    while (obs_a.size() < 4 && g < 200) begin @(negedge clk); g++; end
    g = 0;
    while (!a_ready && g < 50) begin @(negedge clk); g++; end
    chk({tag, " count"}, 64'(obs_a.size()), 64'd4);
    c0 = -1; c3 = -1;
    for (int i = 0; i < 4; i++) begin
      e = exp_a.pop_front();
      if (obs_a.size() > 0) begin
        o  = obs_a.pop_front();
        c3 = obs_a_cyc.pop_front();
        if (i == 0) c0 = c3;
      end else begin
        o = 'x;
      end
      chk($sformatf("%s row%0d", tag, i), 64'(o), 64'(e));
    end
    chk({tag, " latency"}, 64'(c0 - r3c), 64'(LAT_A + 1));
    chk({tag, " contiguous"}, 64'(c3 - c0), 64'd3);
    obs_a.delete(); obs_a_cyc.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r3, g;
    int r3b[$];
    logic crc;
    logic [31:0] last_b;
    logic [35:0] last_r;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset READYO", 64'(a_ready), 64'd1);
    chk("reset FBSTROBE", 64'(a_fbs), 64'd0);
    chk("reset OVERRUN", 64'(a_ovr), 64'd0);
    chk("reset FEEDB", 64'(a_feedb), 64'd0);
    chk("reset FBPENDING", 64'(a_pend), 64'd0);
`ifdef H264_FB_CLIPCOUNT_EN
    chk("reset CLIPCOUNT", 64'(a_clip), 64'd0);
`endif
    @(posedge clk); #1;

    // Partial block killed by reset after two rows.
    a_row(32'h11223344, 36'h0_1234_5678, 1'b1);
    a_row(32'h55667788, 36'h9_8765_4321, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("midreset READYO", 64'(a_ready), 64'd1);
    chk("midreset FBPENDING", 64'(a_pend), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("midreset no feedback", 64'(obs_a.size()), 64'd0);
    clip_a = 0;

    for (int i = 0; i < 4; i++) begin
      blk_b[i] = 32'h10101010;
      blk_r[i] = {4{9'd5}};
    end
    a_send(0, 1'b0, r3);
    a_check("basic", r3);
    chk("basic hold FEEDB", 64'(a_feedb), 64'h15151515);

    rand_blk();
    blk_b[0] = {8'h10, 8'h10, 8'h03, 8'hFA};
    blk_r[0] = {9'd5, 9'd5, 9'h1F7, 9'd20};
    a_send(0, 1'b0, r3);
    a_check("clip", r3);
`ifdef H264_FB_CLIPCOUNT_EN
    chk("clip CLIPCOUNT", 64'(a_clip), 64'(clip_a));
`endif

    rand_blk();
    a_send(3, 1'b1, r3);
    a_check("gaps", r3);

    // Strobe injected while the block is being emitted.
    rand_blk();
    a_send(0, 1'b0, r3);
    g = 0;
    while (obs_a.size() < 1 && g < 50) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    a_row($urandom, 36'({$urandom, $urandom}), 1'b1);
    a_check("overrun", r3);
    chk("overrun flag", 64'(a_ovr), 64'd1);
    rand_blk();
    a_send(1, 1'b1, r3);
    a_check("after overrun", r3);
    chk("overrun sticky", 64'(a_ovr), 64'd1);

    for (int k = 0; k < 4; k++) begin
      rand_blk();
      a_send(int'($urandom_range(0, 2)), 1'(k), r3);
      a_check($sformatf("random%0d", k), r3);
    end
`ifdef H264_FB_CLIPCOUNT_EN
    chk("final CLIPCOUNT a", 64'(a_clip), 64'(clip_a > 65535 ? 65535 : clip_a));
`endif

    // Back-to-back blocks on the zero-latency instance.
    for (int k = 0; k < 3; k++) begin
      g = 0;
      while (!b_ready && g < 100) begin @(posedge clk); #1; g++; end
      crc = 1'(k);
      for (int i = 0; i < 4; i++) begin
        last_b = $urandom;
        last_r = 36'({$urandom, $urandom});
        exp_b.push_back({1'b1, crc, ref_row(last_b, last_r)});
        clip_b += ref_nsat(last_b, last_r);
        if (i == 3) r3b.push_back(cyc);
        b_stb = 1'b1; b_base = last_b; b_dat = last_r; b_crcb = crc ^ i[0];
        @(posedge clk); #1;
      end
      b_stb = 1'b0;
    end
    g = 0;
    while ((obs_b.size() < 12 || !b_ready) && g < 200) begin @(negedge clk); g++; end
    chk("b2b count", 64'(obs_b.size()), 64'd12);
    chk("b2b latency", 64'(obs_b_cyc.size() > 0 ? obs_b_cyc[0] - r3b[0] : -1), 64'd1);
    for (int i = 0; i < 12; i++)
      chk($sformatf("b2b row%0d", i), 64'(obs_b.size() > 0 ? obs_b.pop_front() : 'x),
          64'(exp_b.pop_front()));
    chk("b2b ready runs", 64'(runs_b.size()), 64'd3);
    chk("b2b ready gap1", 64'(runs_b.size() > 1 ? runs_b[1] : -1), 64'd1);
    chk("b2b ready gap2", 64'(runs_b.size() > 2 ? runs_b[2] : -1), 64'd1);
    chk("b2b pending cycles", 64'(pend_b), 64'd21);
    chk("b2b FBPENDING idle", 64'(b_pend), 64'd0);
    chk("b2b OVERRUN", 64'(b_ovr), 64'd0);
`ifdef H264_FB_CLIPCOUNT_EN
    chk("final CLIPCOUNT b", 64'(b_clip), 64'(clip_b));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
